// File: rtl/counter_sequencer.sv
// Command-driven period counter: runs `reps` periods of `limit` ticks, up or down,
// with pause/resume/abort control and single-cycle carry/done/error pulses.
module counter_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             tick_in,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] reps,
    input  logic             dir,
    output logic [WIDTH-1:0] count_out,
    output logic [WIDTH-1:0] rep_out,
    output logic             carry_out,
    output logic             done_out,
    output logic             err_out,
    output logic             busy_out
);

    localparam logic [1:0] OpStart  = 2'b00;
    localparam logic [1:0] OpPause  = 2'b01;
    localparam logic [1:0] OpResume = 2'b10;
    localparam logic [1:0] OpAbort  = 2'b11;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StPause} state_t;

    state_t           state_q;
    logic             busy_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] rep_q;
    logic [WIDTH-1:0] limit_q;
    logic [WIDTH-1:0] reps_q;
    logic             dir_q;
    logic             carry_q;
    logic             done_q;
    logic             err_q;

    logic             tick_ok;
    logic             wrap;
    logic             final_wrap;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] rep_inc;

    // Every command is accepted in a single cycle, in every state.
    assign cmd_ready = 1'b1;

    always_comb begin
        // A PAUSE arriving with a tick discards that tick.
        tick_ok    = tick_in && !(cmd_valid && (cmd_op == OpPause));
        wrap       = dir_q ? (count_q == '0) : (count_q == limit_q - One);
        rep_inc    = rep_q + One;
        final_wrap = wrap && (rep_inc == reps_q);
        if (wrap) begin
            next_count = dir_q ? limit_q - One : '0;
        end else begin
            next_count = dir_q ? count_q - One : count_q + One;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            count_q <= '0;
            rep_q   <= '0;
            limit_q <= '0;
            reps_q  <= '0;
            dir_q   <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid && (cmd_op == OpStart)) begin
                        if ((limit == '0) || (reps == '0)) begin
                            err_q <= 1'b1;
                        end else begin
                            limit_q <= limit;
                            reps_q  <= reps;
                            dir_q   <= dir;
                            count_q <= dir ? limit - One : '0;
                            rep_q   <= '0;
                            state_q <= StRun;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (tick_ok) begin
                        count_q <= next_count;
                        if (wrap) begin
                            carry_q <= 1'b1;
                            rep_q   <= rep_inc;
                        end
                        if (final_wrap) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    // Commands land after the wrap; later assignments take precedence.
                    if (cmd_valid) begin
                        unique case (cmd_op)
                            OpStart: err_q <= 1'b1;
                            OpPause: begin
                                state_q <= StPause;
                                busy_q  <= 1'b1;
                            end
                            OpAbort: begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                count_q <= '0;
                                rep_q   <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                StPause: begin
                    if (cmd_valid) begin
                        unique case (cmd_op)
                            OpStart:  err_q <= 1'b1;
                            OpResume: state_q <= StRun;
                            OpAbort: begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                count_q <= '0;
                                rep_q   <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign count_out = count_q;
    assign rep_out   = rep_q;
    assign carry_out = carry_q;
    assign done_out  = done_q;
    assign err_out   = err_q;
    assign busy_out  = busy_q;

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the count and limit width in bits.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_in, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port tick_in, input, 1, count-enable strobe; a sampled high advances the count by one.
REQ-005 SHALL have port cmd_valid, input, 1, command request.
REQ-006 SHALL have port cmd_ready, output, 1, command accept; a command transfers when cmd_valid and cmd_ready are high at a rising edge.
REQ-007 SHALL have port cmd_op, input, 2, command: 00 START, 01 PAUSE, 10 RESUME, 11 ABORT.
REQ-008 SHALL have port limit, input, WIDTH, period length in ticks, captured on START.
REQ-009 SHALL have port reps, input, WIDTH, number of periods to run, captured on START.
REQ-010 SHALL have port dir, input, 1, direction captured on START: 0 counts up, 1 counts down.
REQ-011 SHALL have port count_out, output, WIDTH, current count within the period.
REQ-012 SHALL have port rep_out, output, WIDTH, number of periods completed.
REQ-013 SHALL have port carry_out, output, 1, one-cycle pulse at each period wrap.
REQ-014 SHALL have port done_out, output, 1, one-cycle pulse when the final period completes.
REQ-015 SHALL have port err_out, output, 1, one-cycle pulse when a command is rejected.
REQ-016 SHALL have port busy_out, output, 1, high in RUN or PAUSE.

Function
REQ-017 SHALL implement the FSM states IDLE, RUN and PAUSE.
REQ-018 SHALL hold cmd_ready high in every state, so each command is accepted in one cycle.
REQ-019 In IDLE, START with limit!=0 and reps!=0 SHALL capture limit, reps and dir and go to RUN next cycle.
REQ-020 On entering RUN from START, count_out SHALL be 0 (up) or limit-1 (down), and rep_out SHALL be 0.
REQ-021 In IDLE, START with limit==0 or reps==0 SHALL pulse err_out and stay in IDLE.
REQ-022 In IDLE, PAUSE, RESUME or ABORT SHALL be ignored, with no error.
REQ-023 In RUN with tick_in high, counting up SHALL increment count_out, and counting down SHALL decrement it.
REQ-024 Counting up, when count_out==limit-1 and tick_in is high, count_out SHALL wrap to 0, carry_out SHALL pulse and rep_out SHALL increment.
REQ-025 Counting down, when count_out==0 and tick_in is high, count_out SHALL wrap to limit-1, carry_out SHALL pulse and rep_out SHALL increment.
REQ-026 When the wrap makes rep_out equal reps, done_out SHALL pulse with carry_out in the same cycle, and the FSM SHALL go to IDLE.
REQ-027 On that final wrap, count_out SHALL take the wrapped value and hold it in IDLE.
REQ-028 limit==1 SHALL give a wrap on every tick; limit==2^WIDTH-1 SHALL count the full range less one.
REQ-029 In RUN, PAUSE SHALL go to PAUSE with counters frozen; a tick_in in the same cycle SHALL be discarded.
REQ-030 In PAUSE, RESUME SHALL return to RUN; tick_in SHALL be ignored while in PAUSE.
REQ-031 In RUN or PAUSE, ABORT SHALL go to IDLE next cycle with count_out and rep_out cleared to 0 and no done_out pulse.
REQ-032 In RUN or PAUSE, START SHALL be rejected with an err_out pulse and no state change.
REQ-033 In RUN, RESUME SHALL be ignored; in PAUSE, PAUSE SHALL be ignored.
REQ-034 A command in the same cycle as a wrap SHALL be applied after the wrap, with the wrap outputs still produced.
REQ-035 ABORT in the same cycle as the final wrap SHALL give done_out and the clear to 0.
REQ-036 Configuration inputs SHALL be ignored except on an accepted START.
REQ-037 carry_out, done_out and err_out SHALL be registered, one cycle wide, and low otherwise.
REQ-038 All outputs SHALL be driven from registers, with no combinational path from inputs.

Reset
REQ-039 While rst_n_in is low, the block SHALL immediately force IDLE, count_out=0, rep_out=0 and busy_out=0.
REQ-040 While rst_n_in is low, carry_out, done_out and err_out SHALL be forced to 0, independent of clk_in.
REQ-041 Reset asserted mid-RUN SHALL discard the run entirely, with no done_out.
REQ-042 After release, the block SHALL accept a command on the first rising edge.

Verification
REQ-043 Up count: START limit=3 reps=2 dir=0, tick every cycle -> count 0,1,2,0,1,2,0; carry_out at both wraps; done_out with the second carry; busy_out falls.
REQ-044 Down count: START limit=4 reps=1 dir=1 -> count 3,2,1,0,3; carry_out and done_out together at the 0->3 wrap.
REQ-045 Pause: limit=5, PAUSE at count 2 with tick high -> count holds 2 through 10 ticks; RESUME -> count continues from 3.
REQ-046 Illegal commands: START limit=0 -> err_out pulse, stays IDLE; START during RUN -> err_out pulse, run unaffected.
REQ-047 Abort: ABORT during PAUSE at count 4, rep 1 -> next cycle IDLE, count_out=0, rep_out=0, no done_out.
REQ-048 Reset: rst_n_in low mid-RUN between clock edges -> outputs 0 without waiting for a clock edge; a START on the first edge after release -> RUN.
